sram_port_arbiter: RTL and testbench

Shares one SRAM-like memory port between the fetch requester (inst_sram_*) and the execute-stage load/store requester (data_sram_*). Sits between the pipeline and the memory bridge. Grants address handshakes with data priority and a starvation guard. Routes each data_ok/rdata back to the requester that issued it, using an in-order ID FIFO of outstanding transactions.

---
 rtl/sram_port_arbiter_pkg.sv | 14 +
 rtl/sram_port_arbiter_order_fifo.sv | 70 +++++++
 rtl/sram_port_arbiter.sv | 132 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   REQ_ID_INST / REQ_ID_DATA : requester identifiers stored in the order FIFO
//   SRAM_REQ_BUS_W            : width of the muxed request bundle
//                               {wr, size, wstrb, addr, wdata} = 1+2+4+32+32
package sram_port_arbiter_pkg;

  typedef logic req_id_t;

  localparam req_id_t REQ_ID_INST = 1'b0;
  localparam req_id_t REQ_ID_DATA = 1'b1;

  localparam int SRAM_REQ_BUS_W = 71;

endpackage

// File: rtl/sram_port_arbiter_order_fifo.sv
// In-order record of which requester owns each outstanding memory transaction.
// 1-bit wide, DEPTH deep (power of two), synchronous active-high reset.
//   clk_i, reset_i : clock, synchronous active-high reset
//   push_i         : record push_id_i at the tail (ignored when full)
//   push_id_i      : requester ID of the accepted transaction
//   pop_i          : retire the head entry (ignored when empty)
//   head_o         : requester ID of the oldest outstanding transaction
//   full_o/empty_o : occupancy flags, derived from the registered count
module sram_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] slot_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Flags come from the registered count, so a pop only frees a slot
  // for the following cycle.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = slot_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says valid.
  always_ff @(posedge clk_i) begin
    if (do_push) slot_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between the fetch requester (inst_sram_*)
// and the load/store requester (data_sram_*).
//   clk, reset            : clock, synchronous active-high reset
//   inst_sram_* / data_sram_* : requester ports (req, wr, size, wstrb, addr,
//                           wdata in; addr_ok, data_ok, rdata out)
//   mem_*                 : downstream port (req, wr, size, wstrb, addr, wdata
//                           out; addr_ok, data_ok, rdata in)
// Handshake semantics: a request is accepted in the cycle where req and
// addr_ok are both high; the requester holds req and all fields stable until
// then. A data_ok cycle returns the oldest accepted transaction; rdata is
// meaningful only in that cycle.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int OT_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SRAM_REQ_BUS_W-1:0] inst_bus, data_bus, mem_bus;
  req_id_t   grant;
  logic      lock_valid_q, lock_valid_d;
  req_id_t   lock_id_q, lock_id_d;
  logic [SC_W-1:0] starve_q, starve_d;
  logic      fifo_full, fifo_empty;
  req_id_t   fifo_head;
  logic      handshake, ret_valid;

  assign inst_bus = {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata};
  assign data_bus = {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata};

  // Grant select. A locked grant pins the downstream request until accepted;
  // otherwise data wins unless inst has been passed over STARVE_LIMIT times.
  always_comb begin
    grant = REQ_ID_DATA;
    if (lock_valid_q)                                      grant = lock_id_q;
    else if (data_sram_req && starve_q < SC_W'(STARVE_LIMIT)) grant = REQ_ID_DATA;
    else if (inst_sram_req)                                grant = REQ_ID_INST;
  end

  assign mem_req   = (inst_sram_req | data_sram_req) & ~fifo_full;
  assign mem_bus   = ~mem_req ? '0 : (grant == REQ_ID_DATA) ? data_bus : inst_bus;
  assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = mem_bus;

  assign handshake         = mem_req & mem_addr_ok;
  assign inst_sram_addr_ok = handshake & (grant == REQ_ID_INST);
  assign data_sram_addr_ok = handshake & (grant == REQ_ID_DATA);

  // A data_ok with nothing outstanding is a protocol error and is dropped.
  assign ret_valid         = mem_data_ok & ~fifo_empty;
  assign inst_sram_data_ok = ret_valid & (fifo_head == REQ_ID_INST);
  assign data_sram_data_ok = ret_valid & (fifo_head == REQ_ID_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  // Lock and starvation-guard next state.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    starve_d     = starve_q;
    if (handshake) begin
      lock_valid_d = 1'b0;
    end else if (mem_req) begin
      lock_valid_d = 1'b1;
      lock_id_d    = grant;
    end
    if (!inst_sram_req) begin
      starve_d = '0;
    end else if (handshake && grant == REQ_ID_INST) begin
      starve_d = '0;
    end else if (handshake && starve_q < SC_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= REQ_ID_INST;
      starve_q     <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      starve_q     <= starve_d;
    end
  end

  sram_order_fifo #(
    .DEPTH (OT_DEPTH)
  ) u_order_fifo (
    .clk_i     (clk),
    .reset_i   (reset),
    .push_i    (handshake),
    .push_id_i (grant),
    .pop_i     (mem_data_ok),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int OT_DEPTH     = 4;
  localparam int STARVE_LIMIT = 4;

  logic        clk, reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  int checks = 0;
  int errors = 0;

  sram_port_arbiter #(.OT_DEPTH(OT_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_inst(input logic req, input logic [31:0] addr);
    inst_sram_req = req; inst_sram_wr = 1'b0; inst_sram_size = 2'b10;
    inst_sram_wstrb = 4'h0; inst_sram_addr = addr; inst_sram_wdata = 32'h0;
  endtask

  task automatic drive_data(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_req = req; data_sram_wr = wr; data_sram_size = 2'b10;
    data_sram_wstrb = wr ? 4'hf : 4'h0; data_sram_addr = addr; data_sram_wdata = wdata;
  endtask

  task automatic drive_mem(input logic aok, input logic dok, input logic [31:0] rd);
    mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
  endtask

  task automatic idle_inputs();
    drive_inst(1'b0, 32'h0);
    drive_data(1'b0, 1'b0, 32'h0, 32'h0);
    drive_mem(1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    mem_data_ok = 1'b1;
    next_cycle();
    sample();
    checks++;
    if ({mem_req, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000",
               {mem_req, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok});
    end
    next_cycle();
    reset = 1'b0;
    mem_data_ok = 1'b0;
  endtask

  task automatic test_single_fetch();
    do_reset();
    drive_inst(1'b1, 32'h1c000000);
    drive_mem(1'b1, 1'b0, 32'h0);
    sample();
    checks++;
    if ({mem_req, mem_addr, inst_sram_addr_ok, data_sram_addr_ok} !== {1'b1, 32'h1c000000, 2'b10}) begin
      errors++; $display("FAIL fetch_accept: got req=%b addr=%h aok=%b%b want 1 1c000000 10",
                         mem_req, mem_addr, inst_sram_addr_ok, data_sram_addr_ok);
    end
    next_cycle();
    drive_inst(1'b0, 32'h0);
    drive_mem(1'b0, 1'b0, 32'h0);
    sample();
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
      errors++; $display("FAIL fetch_early_dok: got %b%b want 00", inst_sram_data_ok, data_sram_data_ok);
    end
    next_cycle();
    drive_mem(1'b0, 1'b1, 32'h02800413);
    sample();
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata} !== {2'b10, 32'h02800413}) begin
      errors++; $display("FAIL fetch_return: got dok=%b%b rdata=%h want 10 02800413",
                         inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
    end
    next_cycle();
    drive_mem(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_conflict();
    do_reset();
    drive_inst(1'b1, 32'h1c000004);
    drive_data(1'b1, 1'b0, 32'h1000, 32'h0);
    drive_mem(1'b1, 1'b0, 32'h0);
    sample();
    checks++;
    if ({inst_sram_addr_ok, data_sram_addr_ok, mem_addr} !== {2'b01, 32'h1000}) begin
      errors++; $display("FAIL conflict_first: got aok=%b%b addr=%h want 01 00001000",
                         inst_sram_addr_ok, data_sram_addr_ok, mem_addr);
    end
    next_cycle();
    drive_data(1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    checks++;
    if ({inst_sram_addr_ok, data_sram_addr_ok, mem_addr} !== {2'b10, 32'h1c000004}) begin
      errors++; $display("FAIL conflict_second: got aok=%b%b addr=%h want 10 1c000004",
                         inst_sram_addr_ok, data_sram_addr_ok, mem_addr);
    end
    next_cycle();
    drive_inst(1'b0, 32'h0);
    drive_mem(1'b0, 1'b1, 32'h11112222);
    sample();
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok, data_sram_rdata} !== {2'b01, 32'h11112222}) begin
      errors++; $display("FAIL conflict_ret_d: got dok=%b%b rdata=%h want 01 11112222",
                         inst_sram_data_ok, data_sram_data_ok, data_sram_rdata);
    end
    next_cycle();
    drive_mem(1'b0, 1'b1, 32'h33334444);
    sample();
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata} !== {2'b10, 32'h33334444}) begin
      errors++; $display("FAIL conflict_ret_i: got dok=%b%b rdata=%h want 10 33334444",
                         inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
    end
    next_cycle();
    drive_mem(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_lock();
    // data locked while inst joins
    do_reset();
    drive_data(1'b1, 1'b0, 32'h1000, 32'h0);
    drive_mem(1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) drive_inst(1'b1, 32'h1c000008);
      sample();
      checks++;
      if ({mem_req, mem_addr, inst_sram_addr_ok, data_sram_addr_ok} !== {1'b1, 32'h1000, 2'b00}) begin
        errors++; $display("FAIL lock_hold_c%0d: got req=%b addr=%h aok=%b%b want 1 00001000 00",
                           c, mem_req, mem_addr, inst_sram_addr_ok, data_sram_addr_ok);
      end
      next_cycle();
    end
    drive_mem(1'b1, 1'b0, 32'h0);
    sample();
    checks++;
    if ({data_sram_addr_ok, inst_sram_addr_ok, mem_addr} !== {2'b10, 32'h1000}) begin
      errors++; $display("FAIL lock_accept: got daok=%b iaok=%b addr=%h want 1 0 00001000",
                         data_sram_addr_ok, inst_sram_addr_ok, mem_addr);
    end
    next_cycle();
    drive_data(1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    checks++;
    if ({inst_sram_addr_ok, mem_addr} !== {1'b1, 32'h1c000008}) begin
      errors++; $display("FAIL lock_then_inst: got iaok=%b addr=%h want 1 1c000008", inst_sram_addr_ok, mem_addr);
    end
    next_cycle();
    drive_inst(1'b0, 32'h0);
    drive_mem(1'b0, 1'b1, 32'h5);
    sample();
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b01) begin
      errors++; $display("FAIL lock_ret_d: got %b%b want 01", inst_sram_data_ok, data_sram_data_ok);
    end
    next_cycle();
    sample();
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10) begin
      errors++; $display("FAIL lock_ret_i: got %b%b want 10", inst_sram_data_ok, data_sram_data_ok);
    end
    // inst locked: a later data request must not steal the port
    do_reset();
    drive_inst(1'b1, 32'h1c00000c);
    next_cycle();
    drive_data(1'b1, 1'b1, 32'h2000, 32'hdeadbeef);
    sample();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h1c00000c}) begin
      errors++; $display("FAIL lock_inst_hold: got req=%b addr=%h want 1 1c00000c", mem_req, mem_addr);
    end
    next_cycle();
    drive_mem(1'b1, 1'b0, 32'h0);
    sample();
    checks++;
    if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL lock_inst_accept: got %b%b want 10", inst_sram_addr_ok, data_sram_addr_ok);
    end
    next_cycle();
    drive_inst(1'b0, 32'h0);
    sample();
    checks++;
    if ({data_sram_addr_ok, mem_wr, mem_addr, mem_wdata} !== {2'b11, 32'h2000, 32'hdeadbeef}) begin
      errors++; $display("FAIL lock_data_store: got daok=%b wr=%b addr=%h wdata=%h want 1 1 00002000 deadbeef",
                         data_sram_addr_ok, mem_wr, mem_addr, mem_wdata);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    drive_mem(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < OT_DEPTH; i++) begin
      drive_inst(1'b1, 32'h1c000000 + 32'(i * 4));
      sample();
      checks++;
      if ({mem_req, inst_sram_addr_ok} !== 2'b11) begin
        errors++; $display("FAIL full_fill_%0d: got req=%b iaok=%b want 1 1", i, mem_req, inst_sram_addr_ok);
      end
      next_cycle();
    end
    drive_inst(1'b1, 32'h1c000010);
    sample();
    checks++;
    if ({mem_req, inst_sram_addr_ok} !== 2'b00) begin
      errors++; $display("FAIL full_block: got req=%b iaok=%b want 0 0", mem_req, inst_sram_addr_ok);
    end
    next_cycle();
    drive_mem(1'b1, 1'b1, 32'h100);
    sample();
    checks++;
    if ({mem_req, inst_sram_addr_ok, inst_sram_data_ok} !== 3'b001) begin
      errors++; $display("FAIL full_pop_same_cycle: got req=%b iaok=%b idok=%b want 0 0 1",
                         mem_req, inst_sram_addr_ok, inst_sram_data_ok);
    end
    next_cycle();
    drive_mem(1'b1, 1'b0, 32'h0);
    sample();
    checks++;
    if ({mem_req, inst_sram_addr_ok, mem_addr} !== {2'b11, 32'h1c000010}) begin
      errors++; $display("FAIL full_lifted: got req=%b iaok=%b addr=%h want 1 1 1c000010",
                         mem_req, inst_sram_addr_ok, mem_addr);
    end
    next_cycle();
    drive_inst(1'b0, 32'h0);
    for (int i = 0; i < OT_DEPTH; i++) begin
      drive_mem(1'b0, 1'b1, 32'h200 + 32'(i));
      sample();
      checks++;
      if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'h200 + 32'(i)}) begin
        errors++; $display("FAIL full_drain_%0d: got idok=%b rdata=%h want 1 %h",
                           i, inst_sram_data_ok, inst_sram_rdata, 32'h200 + 32'(i));
      end
      next_cycle();
    end
    drive_mem(1'b0, 1'b1, 32'hbad);
    sample();
    checks++;
    if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
      errors++; $display("FAIL empty_stray: got %b%b want 00", inst_sram_data_ok, data_sram_data_ok);
    end
    next_cycle();
    drive_mem(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_starvation();
    int acc;
    do_reset();
    drive_inst(1'b1, 32'h1c000020);
    acc = 0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 5) drive_inst(1'b0, 32'h0);
      drive_data(c <= 5, 1'b0, 32'h3000 + 32'(acc * 4), 32'h0);
      drive_mem(c <= 5, c > 0, 32'h500 + 32'(c));
      sample();
      if (c <= 5) begin
        checks++;
        if ({inst_sram_addr_ok, data_sram_addr_ok} !== ((c == 4) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL starve_grant_c%0d: got aok=%b%b want %b", c,
                             inst_sram_addr_ok, data_sram_addr_ok, (c == 4) ? 2'b10 : 2'b01);
        end
      end
      if (c > 0) begin
        checks++;
        if ({inst_sram_data_ok, data_sram_data_ok} !== ((c == 5) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL starve_ret_c%0d: got dok=%b%b want %b", c,
                             inst_sram_data_ok, data_sram_data_ok, (c == 5) ? 2'b10 : 2'b01);
        end
      end
      if (c != 4) acc++;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_stray();
    do_reset();
    drive_mem(1'b1, 1'b0, 32'h0);
    drive_inst(1'b1, 32'h1c000040);
    next_cycle();
    drive_inst(1'b1, 32'h1c000044);
    next_cycle();
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_mem(1'b0, 1'b1, 32'hcafe0000 + 32'(i));
      sample();
      checks++;
      if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
        errors++; $display("FAIL reset_stray_%0d: got %b%b want 00", i, inst_sram_data_ok, data_sram_data_ok);
      end
      next_cycle();
    end
    // all OT_DEPTH slots must be free again, then the next one blocks
    drive_mem(1'b1, 1'b0, 32'h0);
    for (int i = 0; i <= OT_DEPTH; i++) begin
      drive_data(1'b1, 1'b0, 32'h4000 + 32'(i * 4), 32'h0);
      sample();
      checks++;
      if (data_sram_addr_ok !== (i < OT_DEPTH)) begin
        errors++; $display("FAIL reset_count_%0d: got daok=%b want %b", i, data_sram_addr_ok, i < OT_DEPTH);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  // ---------------- randomized run against a reference model ----------------
  task automatic test_random();
    logic [0:0]  exp_q[$];      // requester of each outstanding transaction, oldest first
    logic [70:0] i_bus, d_bus, exp_bus;
    logic        i_pend, d_pend, locked, lock_who, full, any, e_req, who, hs;
    logic        e_iaok, e_daok, e_idok, e_ddok;
    int          starve;
    do_reset();
    exp_q.delete();
    i_pend = 1'b0; d_pend = 1'b0; locked = 1'b0; lock_who = 1'b0; starve = 0;
    i_bus = '0; d_bus = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1'b1;
        i_bus = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 4'($urandom), 32'($urandom), 32'($urandom)};
      end
      if (!d_pend && $urandom_range(0, 3) != 0) begin
        d_pend = 1'b1;
        d_bus = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 4'($urandom), 32'($urandom), 32'($urandom)};
      end
      inst_sram_req = i_pend;
      {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata} = i_bus;
      data_sram_req = d_pend;
      {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata} = d_bus;
      mem_addr_ok = ($urandom_range(0, 9) < 7);
      mem_data_ok = (exp_q.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 29) == 0);
      mem_rdata   = $urandom;
      sample();
      // expected behaviour for this cycle
      full  = (exp_q.size() == OT_DEPTH);
      any   = i_pend | d_pend;
      e_req = any & ~full;
      if (locked)                              who = lock_who;
      else if (d_pend && starve < STARVE_LIMIT) who = 1'b1;
      else if (i_pend)                         who = 1'b0;
      else                                     who = 1'b1;
      hs      = e_req & mem_addr_ok;
      e_iaok  = hs & ~who;
      e_daok  = hs & who;
      e_idok  = mem_data_ok && exp_q.size() > 0 && exp_q[0] == 1'b0;
      e_ddok  = mem_data_ok && exp_q.size() > 0 && exp_q[0] == 1'b1;
      exp_bus = who ? d_bus : i_bus;
      checks++;
      if ({mem_req, inst_sram_addr_ok, data_sram_addr_ok} !== {e_req, e_iaok, e_daok}) begin
        errors++; $display("FAIL rand_req_c%0d: got req/iaok/daok=%b%b%b want %b%b%b", cyc,
                           mem_req, inst_sram_addr_ok, data_sram_addr_ok, e_req, e_iaok, e_daok);
      end
      checks++;
      if ({inst_sram_data_ok, data_sram_data_ok} !== {e_idok, e_ddok}) begin
        errors++; $display("FAIL rand_dok_c%0d: got idok/ddok=%b%b want %b%b", cyc,
                           inst_sram_data_ok, data_sram_data_ok, e_idok, e_ddok);
      end
      if (e_req) begin
        checks++;
        if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== exp_bus) begin
          errors++; $display("FAIL rand_bus_c%0d: got %h want %h", cyc,
                             {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, exp_bus);
        end
      end
      if (e_idok || e_ddok) begin
        checks++;
        if ((e_idok ? inst_sram_rdata : data_sram_rdata) !== mem_rdata) begin
          errors++; $display("FAIL rand_rdata_c%0d: got %h want %h", cyc,
                             e_idok ? inst_sram_rdata : data_sram_rdata, mem_rdata);
        end
      end
      // advance the model
      if (mem_data_ok && exp_q.size() > 0) void'(exp_q.pop_front());
      if (hs) exp_q.push_back(who);
      if (hs)         locked = 1'b0;
      else if (e_req) begin locked = 1'b1; lock_who = who; end
      if (!i_pend)                 starve = 0;
      else if (hs && !who)         starve = 0;
      else if (hs && starve < STARVE_LIMIT) starve++;
      if (e_iaok) i_pend = 1'b0;
      if (e_daok) d_pend = 1'b0;
      next_cycle();
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_conflict();
    test_lock();
    test_full();
    test_starvation();
    test_reset_stray();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
